// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: opcode constants and sequencer state encoding shared by the instr_sequencer slice
package instr_seq_pkg;
  localparam int OP_CLR      = 0;
  localparam int OP_LDA      = 1;
  localparam int OP_LDB0     = 2;
  localparam int OP_LDB1     = 3;
  localparam int OP_ALU_BASE = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction handshake plus datapath control strobes
//   master: drives instr_valid/instr, observes controls (testbench / issuer side)
//   slave : the sequencer; accepts instructions and drives instr_ready, clear, en_a, en_b,
//           en_out, src_sel, alu_sel, done, illegal (and retired_cnt when INSTR_SEQ_PERF_EN)
interface instr_sequencer_if #(
  parameter int OP_W  = 4,
  parameter int SEL_W = 3
);
  logic             instr_valid;
  logic [OP_W-1:0]  instr;
  logic             instr_ready;
  logic             clear;
  logic             en_a;
  logic             en_b;
  logic             en_out;
  logic             src_sel;
  logic [SEL_W-1:0] alu_sel;
  logic             done;
  logic             illegal;
`ifdef INSTR_SEQ_PERF_EN
  logic [15:0]      retired_cnt;
`endif
  modport master (
    output instr_valid, instr,
    input  instr_ready, clear, en_a, en_b, en_out, src_sel, alu_sel, done, illegal
`ifdef INSTR_SEQ_PERF_EN
    , input retired_cnt
`endif
  );
  modport slave (
    input  instr_valid, instr,
    output instr_ready, clear, en_a, en_b, en_out, src_sel, alu_sel, done, illegal
`ifdef INSTR_SEQ_PERF_EN
    , output retired_cnt
`endif
  );
endinterface

// File: rtl/instr_seq_decode.sv
// instr_seq_decode: combinational opcode-to-control classification
//   op_i      : registered opcode
//   clr_o/lda_o/ldb_o/alu_o/ill_o : one-hot opcode class
//   src_o     : operand B source (opcode bit 0, meaningful for LDB)
//   alu_sel_o : ALU function (opcode - OP_ALU_BASE), 0 for non-ALU ops
module instr_seq_decode
  import instr_seq_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int SEL_W = 3
) (
  input  logic [OP_W-1:0]  op_i,
  output logic             clr_o,
  output logic             lda_o,
  output logic             ldb_o,
  output logic             alu_o,
  output logic             ill_o,
  output logic             src_o,
  output logic [SEL_W-1:0] alu_sel_o
);
  // One extra bit so the upper ALU bound cannot wrap when the range reaches 2**OP_W
  localparam logic [OP_W:0] ALU_LO = (OP_W+1)'(OP_ALU_BASE);
  localparam logic [OP_W:0] ALU_HI = (OP_W+1)'(OP_ALU_BASE + 2**SEL_W);
  logic [OP_W:0] op_x;
  assign op_x = {1'b0, op_i};
  always_comb begin
    clr_o     = op_i == OP_W'(OP_CLR);
    lda_o     = op_i == OP_W'(OP_LDA);
    ldb_o     = op_i == OP_W'(OP_LDB0) || op_i == OP_W'(OP_LDB1);
    alu_o     = op_x >= ALU_LO && op_x < ALU_HI;
    ill_o     = !(clr_o || lda_o || ldb_o || alu_o);
    src_o     = op_i[0];
    alu_sel_o = alu_o ? SEL_W'(op_x - ALU_LO) : '0;
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: three-state (IDLE/EXEC/WB) micro-sequencer issuing datapath strobes per opcode
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : instr_sequencer_if.slave (handshake in, control strobes out)
//   Optional feature macro INSTR_SEQ_PERF_EN adds a 16-bit wrapping retired-op counter.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int SEL_W = 3
) (
  input logic               clk,
  input logic               rst_n,
  instr_sequencer_if.slave  bus
);
  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             accept;
  logic             d_clr, d_lda, d_ldb, d_alu, d_ill, d_src;
  logic [SEL_W-1:0] d_alu_sel;
  logic             exec, wb, done;
  instr_seq_decode #(.OP_W(OP_W), .SEL_W(SEL_W)) u_decode (
    .op_i      (op_q),
    .clr_o     (d_clr),
    .lda_o     (d_lda),
    .ldb_o     (d_ldb),
    .alu_o     (d_alu),
    .ill_o     (d_ill),
    .src_o     (d_src),
    .alu_sel_o (d_alu_sel)
  );
  assign accept = bus.instr_valid && state_q == IDLE;
  assign op_d   = accept ? bus.instr : op_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end
  // Only ALU ops take the extra write-back cycle; everything else retires in EXEC
  always_comb begin
    state_d = state_q == IDLE ? (accept ? EXEC : IDLE) :
              (state_q == EXEC && d_alu) ? WB : IDLE;
  end
  always_comb begin
    exec            = state_q == EXEC;
    wb              = state_q == WB;
    done            = (exec && !d_alu) || wb;
    bus.instr_ready = state_q == IDLE;
    bus.clear       = exec && d_clr;
    bus.en_a        = exec && (d_clr || d_lda);
    bus.en_b        = exec && (d_clr || d_ldb);
    bus.en_out      = (exec && d_clr) || wb;
    bus.src_sel     = exec && d_ldb && d_src;
    bus.alu_sel     = ((exec || wb) && d_alu) ? d_alu_sel : '0;
    bus.done        = done;
    bus.illegal     = exec && d_ill;
  end
`ifdef INSTR_SEQ_PERF_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = done ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.retired_cnt = cnt_q;
`endif
endmodule
